// File: rtl/ioport_bank.sv
// rtl/ioport_bank.sv - four-port memory-mapped I/O responder for the tinymips data bus
module ioport_bank #(
    parameter int IN_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          ioport_we,
    input  logic [31:0]         wd,
    input  logic [1:0]          ioport_rd_sel,
    output logic [31:0]         rd,
    input  logic [IN_WIDTH-1:0] port_in,
    output logic [31:0]         port_out0,
    output logic [31:0]         port_out1,
    output logic                edge_irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [31:0]         out0;
    logic [31:0]         out1;
    logic [IN_WIDTH-1:0] sync1;
    logic [IN_WIDTH-1:0] sync2;
    logic [IN_WIDTH-1:0] cand;
    logic [IN_WIDTH-1:0] deb;
    logic [IN_WIDTH-1:0] deb_d;
    logic [IN_WIDTH-1:0] cap;
    logic [CW-1:0]       cnt;

    logic [IN_WIDTH-1:0] rise;
    logic [IN_WIDTH-1:0] clr_mask;
    logic [31:0]         deb_ext;
    logic [31:0]         cap_ext;

    // Port 2 is the input side; the store decode never targets it, so its enable is dropped.
    logic unused_we2;
    assign unused_we2 = ioport_we[2];

    // CPU output registers; each enable bit acts on its own port.
    always_ff @(posedge clk) begin
        if (reset) begin
            out0 <= '0;
            out1 <= '0;
        end else begin
            if (ioport_we[0]) out0 <= wd;
            if (ioport_we[1]) out1 <= wd;
        end
    end

    // Two-flop synchroniser for the whole asynchronous input vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= port_in;
            sync2 <= sync1;
        end
    end

    // Whole-vector debounce: any bit change restarts the stability count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand <= '0;
            cnt  <= '0;
            deb  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end else begin
            deb <= cand;
        end
    end

    // Rising-edge detect on the debounced value and write-1-to-clear mask.
    always_comb begin
        rise     = deb & ~deb_d;
        clr_mask = ioport_we[3] ? wd[IN_WIDTH-1:0] : '0;
    end

    // Edge capture register; a new rise wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d <= '0;
            cap   <= '0;
        end else begin
            deb_d <= deb;
            cap   <= (cap & ~clr_mask) | rise;
        end
    end

    // Read mux straight from state, narrow ports zero-extended to the bus width.
    always_comb begin
        deb_ext = 32'(deb);
        cap_ext = 32'(cap);
        rd      = '0;
        case (ioport_rd_sel)
            2'd0:    rd = out0;
            2'd1:    rd = out1;
            2'd2:    rd = deb_ext;
            default: rd = cap_ext;
        endcase
    end

    assign port_out0 = out0;
    assign port_out1 = out1;
    assign edge_irq  = |cap;

endmodule

// File: tb/tb_ioport_bank.sv
// tb/tb_ioport_bank.sv - directed self-checking bench for ioport_bank
module tb_ioport_bank;

    logic        clk;
    logic        reset;
    logic [3:0]  ioport_we;
    logic [31:0] wd;
    logic [1:0]  ioport_rd_sel;
    logic [31:0] rd;
    logic [15:0] port_in;
    logic [31:0] port_out0;
    logic [31:0] port_out1;
    logic        edge_irq;

    int total;
    int passed;

    ioport_bank #(.IN_WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .ioport_we     (ioport_we),
        .wd            (wd),
        .ioport_rd_sel (ioport_rd_sel),
        .rd            (rd),
        .port_in       (port_in),
        .port_out0     (port_out0),
        .port_out1     (port_out1),
        .edge_irq      (edge_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        ioport_rd_sel = sel;
        #1;
        chk(tag, rd, exp);
    endtask

    initial begin
        total = 0;
        passed = 0;
        reset = 1'b1;
        ioport_we = 4'b0011;
        wd = $urandom;
        ioport_rd_sel = 2'd0;
        port_in = 16'h0000;

        // reset overrides writes issued alongside it
        tick();
        wd = $urandom;
        tick();
        ioport_we = 4'b0000;
        chk("rst_out0", port_out0, 32'h0);
        chk("rst_out1", port_out1, 32'h0);
        chk("rst_irq", {31'b0, edge_irq}, 32'h0);
        rd_chk("rst_rd0", 2'd0, 32'h0);
        rd_chk("rst_rd1", 2'd1, 32'h0);
        rd_chk("rst_rd2", 2'd2, 32'h0);
        rd_chk("rst_rd3", 2'd3, 32'h0);
        reset = 1'b0;
        tick();

        // output register writes; same-cycle read returns old value
        ioport_we = 4'b0001;
        wd = 32'hDEADBEEF;
        rd_chk("wr0_old", 2'd0, 32'h0);
        tick();
        ioport_we = 4'b0010;
        wd = 32'h12345678;
        chk("wr0_out", port_out0, 32'hDEADBEEF);
        tick();
        ioport_we = 4'b0000;
        chk("wr1_out", port_out1, 32'h12345678);
        rd_chk("wr_rd0", 2'd0, 32'hDEADBEEF);
        rd_chk("wr_rd1", 2'd1, 32'h12345678);

        // multi-bit enable writes both ports, bit 2 has no effect
        ioport_we = 4'b0111;
        wd = 32'hA5A5A5A5;
        tick();
        ioport_we = 4'b0000;
        chk("multi_out0", port_out0, 32'hA5A5A5A5);
        chk("multi_out1", port_out1, 32'hA5A5A5A5);
        rd_chk("multi_rd2", 2'd2, 32'h0);

        // debounce latency of 7 clocks, capture one clock later
        port_in = 16'h0005;
        for (int k = 1; k <= 6; k++) begin
            tick();
            rd_chk($sformatf("lat_deb_%0d", k), 2'd2, 32'h0);
        end
        tick();
        rd_chk("lat_deb_7", 2'd2, 32'h5);
        rd_chk("lat_cap_7", 2'd3, 32'h0);
        tick();
        rd_chk("lat_cap_8", 2'd3, 32'h5);
        chk("lat_irq_8", {31'b0, edge_irq}, 32'h1);

        // write-1-to-clear, upper wd bits ignored
        ioport_we = 4'b1000;
        wd = 32'hFFFF0001;
        tick();
        ioport_we = 4'b0000;
        rd_chk("clr1_cap", 2'd3, 32'h4);
        chk("clr1_irq", {31'b0, edge_irq}, 32'h1);
        ioport_we = 4'b1000;
        wd = 32'h00000004;
        tick();
        ioport_we = 4'b0000;
        rd_chk("clr4_cap", 2'd3, 32'h0);
        chk("clr4_irq", {31'b0, edge_irq}, 32'h0);

        // falling edges are not captured
        port_in = 16'h0000;
        for (int k = 0; k < 8; k++) tick();
        rd_chk("fall_deb", 2'd2, 32'h0);
        rd_chk("fall_cap", 2'd3, 32'h0);

        // 3-clock glitch never reaches deb
        port_in = 16'h0001;
        for (int k = 0; k < 3; k++) tick();
        port_in = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            rd_chk($sformatf("glitch_deb_%0d", k), 2'd2, 32'h0);
        end
        rd_chk("glitch_cap", 2'd3, 32'h0);

        // 8-clock pulse passes; clear on the rise cycle loses to the set
        port_in = 16'h0001;
        for (int k = 0; k < 7; k++) tick();
        rd_chk("pulse_deb_on", 2'd2, 32'h1);
        rd_chk("pulse_cap_pre", 2'd3, 32'h0);
        ioport_we = 4'b1000;
        wd = 32'h00000001;
        tick();
        ioport_we = 4'b0000;
        port_in = 16'h0000;
        rd_chk("rise_clr_cap", 2'd3, 32'h1);
        chk("rise_clr_irq", {31'b0, edge_irq}, 32'h1);
        for (int k = 0; k < 6; k++) tick();
        rd_chk("pulse_deb_hold", 2'd2, 32'h1);
        tick();
        rd_chk("pulse_deb_off", 2'd2, 32'h0);
        rd_chk("pulse_cap_kept", 2'd3, 32'h1);

        // reset mid-debounce restarts the full latency
        port_in = 16'h00F0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_chk("mid_rst_deb", 2'd2, 32'h0);
        rd_chk("mid_rst_cap", 2'd3, 32'h0);
        chk("mid_rst_out0", port_out0, 32'h0);
        chk("mid_rst_irq", {31'b0, edge_irq}, 32'h0);
        for (int k = 0; k < 6; k++) tick();
        rd_chk("relat_deb_6", 2'd2, 32'h0);
        tick();
        rd_chk("relat_deb_7", 2'd2, 32'h000000F0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
